wb_regfile: RTL
===============

# wb_regfile

Write-back register file with a hazard scoreboard, at the far end of the MEM→WB path. It consumes the 20-bit write-back packet registered out of the memory stage, commits it to an 8×16 register file, and serves two asynchronous read ports to decode. A per-register pending counter tracks in-flight writers and raises a stall to decode on read-after-write and counter-overflow hazards.

## Interface
Parameters:
- `WIDTH`, 16, register data width; packet data field is `[WIDTH-1:0]`
- `AW`, 3, register index width; `2**AW` registers
- `PW`, 2, pending-counter width; maximum in-flight writers per register is `2**PW-1`

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  asynchronous active-high reset
- `WB_In`  in  20  write-back packet: `[19]` WB enable, `[18:16]` Rdst, `[15:0]` data
- `Rsrc1`, `Rsrc2`  in  3 each  decode read indices
- `Src1_Use`, `Src2_Use`  in  1 each  the decoded instruction actually reads that source
- `Issue`  in  1  decode requests to issue an instruction that will write `Issue_Rdst`
- `Issue_Rdst`  in  3  destination of the issuing instruction
- `Rd1`, `Rd2`  out  16 each  read data
- `Stall`  out  1  decode must hold; issue not accepted
- `Pend_Any`  out  1  at least one pending counter non-zero (drain indicator)

## Operation
- State: `regs[0..7]` (16 b), `pend[0..7]` (PW b).
- Write: if `WB_In[19]`, `regs[WB_In[18:16]] <= WB_In[15:0]` at the edge. Register 0 is a normal register, not hard-wired.
- Read: `Rd1 = regs[Rsrc1]`, `Rd2 = regs[Rsrc2]`, combinational (bypass adjustment under Configuration).
- Hazard terms, combinational: `h1 = Src1_Use & busy(Rsrc1)`, `h2 = Src2_Use & busy(Rsrc2)`, `hf = Issue & (pend[Issue_Rdst] == 2**PW-1)`. `busy(r) = pend[r] != 0` (modified by bypass).
- `Stall = h1 | h2 | hf`; `Stall` is 0 whenever `Issue`, `Src1_Use` and `Src2_Use` are all 0.
- `acc = Issue & ~Stall`.
- Counter update per register r, evaluated independently:
  - inc = `acc & Issue_Rdst == r`; dec = `WB_In[19] & WB_In[18:16] == r & pend[r] != 0`
  - inc & dec: unchanged; inc only: +1; dec only: −1.
  - Write-back to a register with `pend == 0`: data still written, counter stays 0 (no underflow).
  - Counter never wraps: saturation is prevented by `hf`.
- `Pend_Any = |pend` (OR of all counters).

## Timing
- Reset (async assert, sync deassert by system): all `regs` = 0, all `pend` = 0; while `rst` is high, `Stall` = 0, `Pend_Any` = 0, `Rd1`/`Rd2` = 0.
- Reset mid-operation discards all pending state; in-flight packets arriving after release write data and are treated as `pend == 0` write-backs.
- Write-to-read latency: 1 edge without bypass; 0 cycles with bypass.
- Issue-to-stall latency: a dependent source sees `busy` the cycle after `acc`.
- Simultaneous write-back and read of the same register without bypass: `Rd` returns the old value and `Stall` is driven by the pre-edge counter.
- `Issue` with `Stall` high has no effect; decode re-presents the instruction unchanged.

## Configuration
- `WB_BYPASS_EN` defined:
  - When `WB_In[19]` targets r, `Rd1`/`Rd2` reading r return `WB_In[15:0]` in the same cycle.
  - `busy(r)` excludes a write-back that brings `pend[r]` from 1 to 0 in that cycle, unless `acc` re-issues to r in that same cycle.
- `WB_BYPASS_EN` undefined:
  - No forwarding: reads return the register contents only.
  - `busy(r) = pend[r] != 0`.
  - Consumers stall one extra cycle.

## Test plan
- Reset mid-run:
  - Stimulus: load `pend[3]=2`, `regs[3]=0x1234`, then pulse `rst`.
  - Required response: `Rd` for r3 = 0, `Pend_Any` = 0, `Stall` = 0.
- Basic write/read:
  - Stimulus: `WB_In = {1,3'd5,16'hBEEF}`, then `Rsrc1 = 5`.
  - Required response: `Rd1 = 0xBEEF` after the edge; same cycle as the write only with bypass.
- RAW stall:
  - Stimulus: issue with Rdst 2; next cycle `Src1_Use`, `Rsrc1 = 2`.
  - Required response: `Stall = 1` until the write-back `{1,3'd2,16'h00AA}`.
  - Release: stall drops in the write-back cycle with bypass (`Rd1 = 0x00AA`), one cycle later without.
- Counter saturation:
  - Stimulus: three accepted issues to r7, then a fourth `Issue` to r7.
  - Required response: `Stall = 1`, `pend[7]` stays 3.
  - Follow-up: one write-back to r7 drops `pend[7]` to 2 and the fourth issue is accepted.
- Simultaneous issue + write-back:
  - Stimulus: accepted issue to r4 and write-back to r4 (`pend[4]=1`) in the same cycle.
  - Required response: `pend[4]` stays 1, `Stall` for a reader of r4 = 1 even with bypass.
- Spurious write-back:
  - Stimulus: `{1,3'd6,16'h0F0F}` with `pend[6]=0`.
  - Required response: `regs[6] = 0x0F0F`, `pend[6] = 0`, `Pend_Any` unchanged.

Source files
------------

// File: rtl/wb_regfile_if.sv
// Decode/write-back bus of the write-back register file: WB packet in, read ports and hazard status out.
interface wb_regfile_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
);
    logic [WIDTH+AW:0] WB_In;
    logic [AW-1:0]     Rsrc1;
    logic [AW-1:0]     Rsrc2;
    logic              Src1_Use;
    logic              Src2_Use;
    logic              Issue;
    logic [AW-1:0]     Issue_Rdst;
    logic [WIDTH-1:0]  Rd1;
    logic [WIDTH-1:0]  Rd2;
    logic              Stall;
    logic              Pend_Any;

    modport master (
        output WB_In, Rsrc1, Rsrc2, Src1_Use, Src2_Use, Issue, Issue_Rdst,
        input  Rd1, Rd2, Stall, Pend_Any
    );

    modport slave (
        input  WB_In, Rsrc1, Rsrc2, Src1_Use, Src2_Use, Issue, Issue_Rdst,
        output Rd1, Rd2, Stall, Pend_Any
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back register file with per-register pending-writer scoreboard and RAW/overflow stall.
// Optional same-cycle write-back forwarding is enabled by defining WB_BYPASS_EN.
module wb_regfile #(
    parameter int WIDTH = 16,
    parameter int AW    = 3,
    parameter int PW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    wb_regfile_if.slave   bus
);
    localparam int            NREG      = 2**AW;
    localparam logic [PW-1:0] PEND_MAX  = {PW{1'b1}};
    localparam logic [PW-1:0] PEND_ONE  = PW'(1);
    localparam logic [PW-1:0] PEND_ZERO = '0;

    logic [WIDTH-1:0] regs_r [NREG];
    logic [PW-1:0]    pend_r [NREG];

    logic             wb_en_s;
    logic [AW-1:0]    wb_dst_s;
    logic [WIDTH-1:0] wb_data_s;
    logic [NREG-1:0]  wb_hit_s;
    logic [NREG-1:0]  busy_s;
    logic [NREG-1:0]  inc_s;
    logic [NREG-1:0]  dec_s;
    logic             h1_s;
    logic             h2_s;
    logic             hf_s;
    logic             stall_s;
    logic             acc_s;
    logic             pend_any_s;
    logic [WIDTH-1:0] rd1_s;
    logic [WIDTH-1:0] rd2_s;

    assign {wb_en_s, wb_dst_s, wb_data_s} = bus.WB_In;

    // Per-register write-back hit and busy status seen by decode.
    // The re-issue exception keys on Issue rather than the accepted issue: when they differ
    // Stall is already high, and this keeps busy -> Stall -> accept free of a loop.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            wb_hit_s[r] = wb_en_s && (wb_dst_s == AW'(r));
`ifdef WB_BYPASS_EN
            if (wb_hit_s[r] && (pend_r[r] == PEND_ONE) &&
                !(bus.Issue && (bus.Issue_Rdst == AW'(r)))) begin
                busy_s[r] = 1'b0;
            end else begin
                busy_s[r] = (pend_r[r] != PEND_ZERO);
            end
`else
            busy_s[r] = (pend_r[r] != PEND_ZERO);
`endif
        end
    end

    // Hazard terms, stall and issue acceptance.
    always_comb begin
        h1_s    = bus.Src1_Use && busy_s[bus.Rsrc1];
        h2_s    = bus.Src2_Use && busy_s[bus.Rsrc2];
        hf_s    = bus.Issue && (pend_r[bus.Issue_Rdst] == PEND_MAX);
        stall_s = !rst && (h1_s || h2_s || hf_s);
        acc_s   = bus.Issue && !stall_s;
    end

    // Counter increment/decrement requests; decrement never underflows.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            inc_s[r] = acc_s && (bus.Issue_Rdst == AW'(r));
            dec_s[r] = wb_hit_s[r] && (pend_r[r] != PEND_ZERO);
        end
    end

    // Drain indicator: any register still has writers in flight.
    always_comb begin
        pend_any_s = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            pend_any_s = pend_any_s | (pend_r[r] != PEND_ZERO);
        end
    end

    // Asynchronous read ports, with optional forwarding of the current write-back.
    always_comb begin
        if (rst) begin
            rd1_s = '0;
        end
`ifdef WB_BYPASS_EN
        else if (wb_hit_s[bus.Rsrc1]) begin
            rd1_s = wb_data_s;
        end
`endif
        else begin
            rd1_s = regs_r[bus.Rsrc1];
        end

        if (rst) begin
            rd2_s = '0;
        end
`ifdef WB_BYPASS_EN
        else if (wb_hit_s[bus.Rsrc2]) begin
            rd2_s = wb_data_s;
        end
`endif
        else begin
            rd2_s = regs_r[bus.Rsrc2];
        end
    end

    // Register file commit and pending-counter update; hf_s keeps counters from wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_r[r] <= '0;
                pend_r[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (wb_hit_s[r]) begin
                    regs_r[r] <= wb_data_s;
                end
                if (inc_s[r] && !dec_s[r]) begin
                    pend_r[r] <= pend_r[r] + PEND_ONE;
                end else if (dec_s[r] && !inc_s[r]) begin
                    pend_r[r] <= pend_r[r] - PEND_ONE;
                end
            end
        end
    end

    assign bus.Rd1      = rd1_s;
    assign bus.Rd2      = rd2_s;
    assign bus.Stall    = stall_s;
    assign bus.Pend_Any = pend_any_s;
endmodule
